ro_puf_eval_ctrl: RTL
=====================

// Module: ro_puf_eval_ctrl
// PURPOSE
//  Parametrised ring-oscillator PUF evaluation controller: latches a challenge,
//  drives two oscillator-bank mux selects, counts synchronised rising edges of
//  both selected ROs over a fixed clk-timed window, compares counts and emits
//  one response bit with valid/tie flags. It sits between the RO banks/muxes
//  and the tile I/O, replacing free-running, reset-polarity-fragile counters.
// PARAMETERS
//  SEL_W       5    width of each bank select (bank depth = 2**SEL_W ROs)
//  CNT_W       16   edge-counter width; counters saturate at all-ones
//  SETTLE_CYC  4    clk cycles of oscillator settle before counting (>=1)
//  WIN_CYC     256  clk cycles of counting window (>=1)
//  NVOTE       3    evaluations per response when PUF_MAJORITY_EN set; odd, >=1
// PORTS
//  clk         in   1       system clock; must exceed 2x max RO frequency
//  rst_n       in   1       reset, asynchronous, active-high
//  start       in   1       evaluation request, sampled in IDLE only
//  chal_a      in   SEL_W   challenge: select for bank A
//  chal_b      in   SEL_W   challenge: select for bank B
//  ro_a        in   1       selected RO output of bank A (async)
//  ro_b        in   1       selected RO output of bank B (async)
//  osc_en      out  1       enable to all ROs
//  sel_a       out  SEL_W   latched bank A select
//  sel_b       out  SEL_W   latched bank B select
//  busy        out  1       high in any state other than IDLE
//  resp_valid  out  1       one-cycle pulse: resp_bit/resp_tie updated
//  resp_bit    out  1       1 when cnt_a > cnt_b (majority result if enabled)
//  resp_tie    out  1       1 when final compare had cnt_a == cnt_b
//  cnt_a_o     out  CNT_W   last window count, bank A
//  cnt_b_o     out  CNT_W   last window count, bank B
// BEHAVIOUR
//  - Reset (async): state IDLE; all outputs, counters and vote tally 0.
//  - FSM: IDLE -> ARM -> COUNT -> CMP -> (IDLE | ARM for next vote).
//  - start high at edge k in IDLE: sel_a/sel_b latch chal_*; counters clear;
//    ARM occupies cycles k+1..k+SETTLE_CYC with osc_en=1.
//  - COUNT occupies the next WIN_CYC cycles; each counter increments by 1 per
//    rising edge of its 2-FF-synchronised RO input detected in COUNT only.
//    Edges in the sync pipeline during ARM/CMP are discarded.
//  - Counter at 2**CNT_W-1 holds (saturation, no wrap).
//  - CMP: 1 cycle, osc_en=0, cnt_*_o updated, compare done.
//  - Single-eval latency: resp_valid high at cycle k+SETTLE_CYC+WIN_CYC+2, with
//    state back in IDLE; resp_bit/resp_tie/cnt_*_o hold until next resp_valid.
//  - Tie (incl. both saturated): resp_bit=0, resp_tie=1.
//  - start while busy: ignored; chal_* changes while busy: ignored.
//  - start in the same cycle resp_valid pulses: accepted (state is IDLE).
//  - Reset mid-operation: osc_en drops asynchronously; no resp_valid issued.
// CONFIGURATION
//  PUF_MAJORITY_EN defined: CMP loops to ARM until NVOTE evaluations done (counters
//   cleared each pass, selects unchanged); resp_bit = majority of per-pass bits;
//   resp_tie = 1 if any pass tied; resp_valid only after the final pass;
//   cnt_*_o show the last pass.
//  Undefined: exactly one evaluation; NVOTE ignored; no vote tally logic.
// STRUCTURE
//  - puf_pkg: FSM state enum (IDLE/ARM/COUNT/CMP), default parameter constants.
//  - Sub-module ro_edge_counter (x2): 2-FF sync, rising-edge detect, sync clear,
//    count enable, saturating CNT_W counter.
//  - Top: FSM, window/settle timer, select latches, comparator, vote tally.
// TESTING  (SETTLE_CYC=4, WIN_CYC=100, CNT_W=16 unless stated)
//  - ro_a period 4 clk, ro_b period 5 clk, start -> resp_valid at k+106,
//    cnt_a_o=25, cnt_b_o=20, resp_bit=1, resp_tie=0.
//  - Both periods 5 clk, phase aligned -> cnt_a_o=cnt_b_o=20, resp_bit=0,
//    resp_tie=1.
//  - CNT_W=4, ro_a period 4, ro_b period 5 -> both saturate at 15, tie=1.
//  - rst_n high during COUNT -> osc_en 0 same cycle, busy 0, no resp_valid;
//    next start evaluates normally.
//  - start pulses at k+3 and k+50 after an accepted start -> ignored; exactly
//    one resp_valid; sel_a/sel_b stay at the first challenge.
//  - PUF_MAJORITY_EN, NVOTE=3, ro_b period swept 3/5/5 clk across passes, ro_a
//    period 4 -> pass bits 0/1/1, resp_bit=1, single resp_valid at k+318.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and defaults for the ring-oscillator PUF evaluation controller.
package puf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2,
    ST_CMP   = 2'd3
  } puf_state_e;

  localparam int unsigned DEF_SEL_W      = 5;
  localparam int unsigned DEF_CNT_W      = 16;
  localparam int unsigned DEF_SETTLE_CYC = 4;
  localparam int unsigned DEF_WIN_CYC    = 256;
  localparam int unsigned DEF_NVOTE      = 3;

  // Register width needed to hold v, never less than one bit.
  function automatic int unsigned bits_for(input int unsigned v);
    return (v == 0) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Counts rising edges of an asynchronous RO input: 2-FF synchroniser, edge detect,
// synchronous clear, count enable and a counter that saturates at all-ones.
module ro_edge_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  // [0],[1] form the synchroniser; [2] holds the previous synchronised level
  logic [2:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise;

  assign rise = sync_q[1] & ~sync_q[2];

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && rise && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[1:0], ro_i};
      cnt_q  <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ro_puf_eval_ctrl.sv
// RO PUF evaluation controller: latches a challenge, times settle and count window, compares counts.
// Build option PUF_MAJORITY_EN: repeat the evaluation NVOTE times and output the majority bit.
module ro_puf_eval_ctrl
  import puf_pkg::*;
#(
  parameter int unsigned SEL_W      = DEF_SEL_W,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int unsigned WIN_CYC    = DEF_WIN_CYC,
  parameter int unsigned NVOTE      = DEF_NVOTE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SEL_W-1:0] chal_a,
  input  logic [SEL_W-1:0] chal_b,
  input  logic             ro_a,
  input  logic             ro_b,
  output logic             osc_en,
  output logic [SEL_W-1:0] sel_a,
  output logic [SEL_W-1:0] sel_b,
  output logic             busy,
  output logic             resp_valid,
  output logic             resp_bit,
  output logic             resp_tie,
  output logic [CNT_W-1:0] cnt_a_o,
  output logic [CNT_W-1:0] cnt_b_o
);

  localparam int unsigned TMR_MAX = (SETTLE_CYC > WIN_CYC - 1) ? SETTLE_CYC : WIN_CYC - 1;
  localparam int unsigned TMR_W   = bits_for(TMR_MAX);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] WIN_LD    = TMR_W'(WIN_CYC - 1);

  puf_state_e       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [SEL_W-1:0] sel_a_q, sel_b_q;
  logic [CNT_W-1:0] cnt_a_q, cnt_b_q;
  logic [CNT_W-1:0] cnt_a, cnt_b;
  logic             osc_en_q, busy_q, resp_valid_q, resp_bit_q, resp_tie_q;
  logic             load_sel, clr, cnt_en, done;
  logic             a_gt, a_eq, res_bit_d, res_tie_d;

`ifdef PUF_MAJORITY_EN
  localparam int unsigned VOTE_W = bits_for(NVOTE);
  localparam int unsigned PASS_W = bits_for(NVOTE);
  // Re-arm spends one extra cycle so every pass spans the same length as a single evaluation.
  localparam logic [TMR_W-1:0] REARM_LD = TMR_W'(SETTLE_CYC);

  logic [VOTE_W-1:0] votes_q, votes_tot;
  logic [PASS_W-1:0] pass_q;
  logic              tie_any_q, rearm;
`else
  logic unused_cfg;
  assign unused_cfg = (NVOTE != 0);
`endif

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    load_sel = 1'b0;
    clr      = 1'b0;
    done     = 1'b0;
`ifdef PUF_MAJORITY_EN
    rearm    = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_ARM;
          tmr_d    = SETTLE_LD;
          load_sel = 1'b1;
          clr      = 1'b1;
        end
      end
      ST_ARM: begin
        if (tmr_q == '0) begin
          state_d = ST_COUNT;
          tmr_d   = WIN_LD;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_COUNT: begin
        if (tmr_q == '0) begin
          state_d = ST_CMP;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_CMP: begin
`ifdef PUF_MAJORITY_EN
        if (pass_q == PASS_W'(NVOTE - 1)) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end else begin
          state_d = ST_ARM;
          tmr_d   = REARM_LD;
          clr     = 1'b1;
          rearm   = 1'b1;
        end
`else
        state_d = ST_IDLE;
        done    = 1'b1;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cnt_en = (state_q == ST_COUNT);
  assign a_gt   = (cnt_a > cnt_b);
  assign a_eq   = (cnt_a == cnt_b);

  always_comb begin
    res_bit_d = a_gt;
    res_tie_d = a_eq;
`ifdef PUF_MAJORITY_EN
    votes_tot = votes_q + VOTE_W'(a_gt);
    res_bit_d = (votes_tot > VOTE_W'(NVOTE / 2));
    res_tie_d = tie_any_q | a_eq;
`endif
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= ST_IDLE;
      tmr_q        <= '0;
      sel_a_q      <= '0;
      sel_b_q      <= '0;
      osc_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_bit_q   <= 1'b0;
      resp_tie_q   <= 1'b0;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      osc_en_q     <= (state_d == ST_ARM) || (state_d == ST_COUNT);
      busy_q       <= (state_d != ST_IDLE);
      resp_valid_q <= done;
      if (load_sel) begin
        sel_a_q <= chal_a;
        sel_b_q <= chal_b;
      end
      if (done) begin
        resp_bit_q <= res_bit_d;
        resp_tie_q <= res_tie_d;
        cnt_a_q    <= cnt_a;
        cnt_b_q    <= cnt_b;
      end
    end
  end

`ifdef PUF_MAJORITY_EN
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pass_q    <= '0;
      votes_q   <= '0;
      tie_any_q <= 1'b0;
    end else if (load_sel) begin
      pass_q    <= '0;
      votes_q   <= '0;
      tie_any_q <= 1'b0;
    end else if (rearm) begin
      pass_q    <= pass_q + 1'b1;
      votes_q   <= votes_tot;
      tie_any_q <= res_tie_d;
    end
  end
`endif

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .ro_i  (ro_a),
    .clr_i (clr),
    .en_i  (cnt_en),
    .cnt_o (cnt_a)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .ro_i  (ro_b),
    .clr_i (clr),
    .en_i  (cnt_en),
    .cnt_o (cnt_b)
  );

  assign osc_en     = osc_en_q;
  assign sel_a      = sel_a_q;
  assign sel_b      = sel_b_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_bit   = resp_bit_q;
  assign resp_tie   = resp_tie_q;
  assign cnt_a_o    = cnt_a_q;
  assign cnt_b_o    = cnt_b_q;

endmodule
